// File: rtl/stepper_move_planner.sv
// Linear-move planner feeding two StepperCtrl axes: the minor-axis pulse width is scaled by
// long/short so both axes finish together, then both are triggered and their completions joined.
module stepper_move_planner #(
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clk_en,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic signed [PULSE_NUM_BITS-1:0]   cmd_dx,
  input  logic signed [PULSE_NUM_BITS-1:0]   cmd_dy,
  input  logic        [PULSE_WIDTH_BITS-1:0] cmd_width,
  output logic                               x_trigger,
  output logic signed [PULSE_NUM_BITS-1:0]   x_pulse_num,
  output logic        [PULSE_WIDTH_BITS-1:0] x_pulse_width,
  input  logic                               x_done,
  output logic                               y_trigger,
  output logic signed [PULSE_NUM_BITS-1:0]   y_pulse_num,
  output logic        [PULSE_WIDTH_BITS-1:0] y_pulse_width,
  input  logic                               y_done,
  output logic                               busy,
  output logic                               done,
  output logic [2:0]                         state_dbg
);
  localparam int PNB = PULSE_NUM_BITS;
  localparam int PWB = PULSE_WIDTH_BITS;
  localparam int NB  = PNB + PWB;
  localparam int CW  = $clog2(NB);

  // Handshake: a command transfers on a clk_en cycle where cmd_valid and cmd_ready are both high.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIVIDE  = 3'd1,
    S_TRIGGER = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic signed [PNB-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic [PWB-1:0]         width_q, width_d;
  logic                   x_major_q, x_major_d;
  logic [PNB-1:0]         short_q, short_d;
  logic [NB-1:0]          num_q, num_d, quo_q, quo_d;
  logic [PNB-1:0]         rem_q, rem_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   x_trig_q, x_trig_d, y_trig_q, y_trig_d;
  logic signed [PNB-1:0]  x_num_q, x_num_d, y_num_q, y_num_d;
  logic [PWB-1:0]         x_wid_q, x_wid_d, y_wid_q, y_wid_d;
  logic                   x_flag_q, x_flag_d, y_flag_q, y_flag_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic [PNB-1:0]         abs_dx, abs_dy, long_c, short_c;
  logic                   cmd_x_major;
  logic [NB-1:0]          prod_c, quo_next;
  logic [PNB:0]           rem_shift, rem_sub;
  logic                   div_ge;
  logic [PWB-1:0]         quo_sat;
  logic signed [PNB-1:0]  ld_dx, ld_dy;
  logic [PWB-1:0]         ld_w, ld_minor;
  logic                   ld_xmaj, load_out;

  // |d| is taken as unsigned so the most negative count maps to +2^(PNB-1).
  always_comb begin
    abs_dx      = cmd_dx[PNB-1] ? (~$unsigned(cmd_dx) + 1'b1) : $unsigned(cmd_dx);
    abs_dy      = cmd_dy[PNB-1] ? (~$unsigned(cmd_dy) + 1'b1) : $unsigned(cmd_dy);
    cmd_x_major = (abs_dx >= abs_dy);
    long_c      = cmd_x_major ? abs_dx : abs_dy;
    short_c     = cmd_x_major ? abs_dy : abs_dx;
    prod_c      = NB'(long_c) * NB'(cmd_width);
    rem_shift   = {rem_q, num_q[NB-1]};
    div_ge      = (rem_shift >= {1'b0, short_q});
    rem_sub     = div_ge ? (rem_shift - {1'b0, short_q}) : rem_shift;
    quo_next    = {quo_q[NB-2:0], div_ge};
    quo_sat     = (|quo_next[NB-1:PWB]) ? '1 : quo_next[PWB-1:0];
    ld_dx       = (state_q == S_IDLE) ? cmd_dx : dx_q;
    ld_dy       = (state_q == S_IDLE) ? cmd_dy : dy_q;
    ld_w        = (state_q == S_IDLE) ? cmd_width : width_q;
    ld_xmaj     = (state_q == S_IDLE) ? cmd_x_major : x_major_q;
    ld_minor    = (state_q == S_IDLE) ? '0 : quo_sat;
  end

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    width_d   = width_q;
    x_major_d = x_major_q;
    short_d   = short_q;
    num_d     = num_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    x_trig_d  = x_trig_q;
    y_trig_d  = y_trig_q;
    x_num_d   = x_num_q;
    y_num_d   = y_num_q;
    x_wid_d   = x_wid_q;
    y_wid_d   = y_wid_q;
    x_flag_d  = x_flag_q;
    y_flag_d  = y_flag_q;
    busy_d    = busy_q;
    done_d    = done_q;
    load_out  = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dx_d      = cmd_dx;
            dy_d      = cmd_dy;
            width_d   = cmd_width;
            x_major_d = cmd_x_major;
            short_d   = short_c;
            num_d     = prod_c;
            quo_d     = '0;
            rem_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            if (long_c == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (short_c == '0) begin
              state_d  = S_TRIGGER;
              load_out = 1'b1;
            end else begin
              state_d = S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          num_d = num_q << 1;
          rem_d = rem_sub[PNB-1:0];
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NB - 1)) begin
            state_d  = S_TRIGGER;
            load_out = 1'b1;
          end
        end
        S_TRIGGER: begin
          x_trig_d = 1'b0;
          y_trig_d = 1'b0;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          x_flag_d = x_flag_q | x_done;
          y_flag_d = y_flag_q | y_done;
          if (x_flag_d && y_flag_d) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          done_d   = 1'b0;
          busy_d   = 1'b0;
          x_num_d  = '0;
          y_num_d  = '0;
          x_wid_d  = '0;
          y_wid_d  = '0;
          x_flag_d = 1'b0;
          y_flag_d = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // An axis with zero steps is neither triggered nor waited for.
    if (load_out) begin
      x_trig_d = (ld_dx != '0);
      y_trig_d = (ld_dy != '0);
      x_num_d  = ld_dx;
      y_num_d  = ld_dy;
      x_wid_d  = (ld_dx == '0) ? '0 : (ld_xmaj ? ld_w : ld_minor);
      y_wid_d  = (ld_dy == '0) ? '0 : (ld_xmaj ? ld_minor : ld_w);
      x_flag_d = (ld_dx == '0);
      y_flag_d = (ld_dy == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dx_q      <= '0;
      dy_q      <= '0;
      width_q   <= '0;
      x_major_q <= 1'b0;
      short_q   <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      x_trig_q  <= 1'b0;
      y_trig_q  <= 1'b0;
      x_num_q   <= '0;
      y_num_q   <= '0;
      x_wid_q   <= '0;
      y_wid_q   <= '0;
      x_flag_q  <= 1'b0;
      y_flag_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      width_q   <= width_d;
      x_major_q <= x_major_d;
      short_q   <= short_d;
      num_q     <= num_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      x_trig_q  <= x_trig_d;
      y_trig_q  <= y_trig_d;
      x_num_q   <= x_num_d;
      y_num_q   <= y_num_d;
      x_wid_q   <= x_wid_d;
      y_wid_q   <= y_wid_d;
      x_flag_q  <= x_flag_d;
      y_flag_q  <= y_flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready     = reset & (state_q == S_IDLE);
  assign x_trigger     = x_trig_q;
  assign y_trigger     = y_trig_q;
  assign x_pulse_num   = x_num_q;
  assign y_pulse_num   = y_num_q;
  assign x_pulse_width = x_wid_q;
  assign y_pulse_width = y_wid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_stepper_move_planner.sv
// Bench for stepper_move_planner: a timeline model of each move (accept, trigger, completion)
// is checked against the DUT outputs on every clock, plus directed literal expectations.
module tb_stepper_move_planner;
  localparam int NB = 16;

  logic              clk = 1'b0, reset = 1'b0, clk_en = 1'b0, cmd_valid = 1'b0;
  logic signed [7:0] cmd_dx = '0, cmd_dy = '0;
  logic [7:0]        cmd_width = '0;
  logic              x_done = 1'b0, y_done = 1'b0;
  logic              cmd_ready, x_trigger, y_trigger, busy, done;
  logic signed [7:0] x_pulse_num, y_pulse_num;
  logic [7:0]        x_pulse_width, y_pulse_width;
  logic [2:0]        state_dbg;

  int n_cmp = 0, n_err = 0;

  stepper_move_planner #(.PULSE_NUM_BITS(8), .PULSE_WIDTH_BITS(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_width(cmd_width),
    .x_trigger(x_trigger), .x_pulse_num(x_pulse_num), .x_pulse_width(x_pulse_width), .x_done(x_done),
    .y_trigger(y_trigger), .y_pulse_num(y_pulse_num), .y_pulse_width(y_pulse_width), .y_done(y_done),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock/reset block: clk_en is clk/2, changed away from the active edge
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #2 clk_en = ~clk_en;
  end

  // reference model: per move, the tick of trigger and of done follow from the rules
  int tick_n = 0, acc_cnt = 0;
  bit m_active = 0, m_zero = 0, m_need_x = 0, m_need_y = 0, m_got_x = 0, m_got_y = 0;
  int m_trig = 0, m_d = -1, m_end = -1;
  logic signed [7:0] m_xn, m_yn;
  logic [7:0] m_xw, m_yw;
  logic e_busy = 0, e_done = 0, e_xt = 0, e_yt = 0;
  logic [7:0] e_xn = '0, e_yn = '0, e_xw = '0, e_yw = '0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_accept();
    int ax, ay, lng, sht, w, q;
    bit xmaj;
    ax = iabs(int'(cmd_dx));
    ay = iabs(int'(cmd_dy));
    w = int'(cmd_width);
    xmaj = (ax >= ay);
    lng = xmaj ? ax : ay;
    sht = xmaj ? ay : ax;
    q = (sht == 0) ? 0 : (w * lng) / sht;
    if (q > 255) q = 255;
    m_active = 1;
    acc_cnt++;
    m_zero = (lng == 0);
    m_need_x = (ax != 0);
    m_need_y = (ay != 0);
    m_got_x = 0;
    m_got_y = 0;
    m_xn = cmd_dx;
    m_yn = cmd_dy;
    m_xw = (ax == 0) ? 8'd0 : (xmaj ? 8'(w) : 8'(q));
    m_yw = (ay == 0) ? 8'd0 : (xmaj ? 8'(q) : 8'(w));
    m_trig = tick_n + ((sht == 0) ? 1 : NB + 1) - 1;
    m_d = m_zero ? tick_n : -1;
    m_end = m_zero ? tick_n + 1 : -1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0;
      m_d = -1;
      m_end = -1;
      e_busy = 0; e_done = 0; e_xt = 0; e_yt = 0;
      e_xn = '0; e_yn = '0; e_xw = '0; e_yw = '0;
    end else if (clk_en) begin
      bit show;
      tick_n++;
      if (m_active) begin
        if (tick_n == m_end) m_active = 0;
        else if (!m_zero && m_d < 0 && tick_n >= m_trig + 2) begin
          m_got_x = m_got_x | x_done;
          m_got_y = m_got_y | y_done;
          if ((m_got_x || !m_need_x) && (m_got_y || !m_need_y)) begin
            m_d = tick_n;
            m_end = tick_n + 1;
          end
        end
      end else if (cmd_valid) begin
        model_accept();
      end
      show = m_active && !m_zero && (tick_n >= m_trig);
      e_busy = m_active;
      e_done = m_active && (tick_n == m_d);
      e_xt = m_active && !m_zero && (tick_n == m_trig) && m_need_x;
      e_yt = m_active && !m_zero && (tick_n == m_trig) && m_need_y;
      e_xn = show ? m_xn : 8'd0;
      e_yn = show ? m_yn : 8'd0;
      e_xw = show ? m_xw : 8'd0;
      e_yw = show ? m_yw : 8'd0;
    end
  end

  // scoreboard
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk1("cmd_ready", cmd_ready, reset && !m_active);
    chk1("busy", busy, e_busy);
    chk1("done", done, e_done);
    chk1("x_trigger", x_trigger, e_xt);
    chk1("y_trigger", y_trigger, e_yt);
    chk8("x_pulse_num", x_pulse_num, e_xn);
    chk8("y_pulse_num", y_pulse_num, e_yn);
    chk8("x_pulse_width", x_pulse_width, e_xw);
    chk8("y_pulse_width", y_pulse_width, e_yw);
  end

  // driver tasks
  task automatic step();
    int t0 = tick_n;
    int g = 0;
    do begin
      @(posedge clk);
      #3;
      g++;
    end while (tick_n == t0 && g < 8);
  endtask

  task automatic start_move(input int dx, input int dy, input int w, input bit hold);
    int a0 = acc_cnt;
    int g = 0;
    cmd_dx = 8'(dx);
    cmd_dy = 8'(dy);
    cmd_width = 8'(w);
    cmd_valid = 1'b1;
    while (acc_cnt == a0 && g < 200) begin
      step();
      g++;
    end
    n_cmp++;
    if (acc_cnt == a0) begin
      n_err++;
      $display("FAIL accept_timeout dx=%0d dy=%0d actual=not_accepted required=accepted", dx, dy);
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic finish_move(input int xdel, input int ydel, input bit hold, input bit lit,
                             input int lxn, input int lyn, input int lxw, input int lyw);
    int g = 0;
    if (lit && m_zero) begin
      chk1("lit_zero_done", done, 1'b1);
      chk1("lit_zero_xtrig", x_trigger, 1'b0);
    end
    while (m_active && g < 400) begin
      if (lit && !m_zero && tick_n == m_trig) begin
        chk1("lit_xtrig", x_trigger, lxn != 0);
        chk1("lit_ytrig", y_trigger, lyn != 0);
        chk8("lit_xnum", x_pulse_num, 8'(lxn));
        chk8("lit_ynum", y_pulse_num, 8'(lyn));
        chk8("lit_xw", x_pulse_width, 8'(lxw));
        chk8("lit_yw", y_pulse_width, 8'(lyw));
      end
      x_done = !m_zero && m_need_x && (tick_n + 1 == m_trig + xdel);
      y_done = !m_zero && m_need_y && (tick_n + 1 == m_trig + ydel);
      if (hold) begin
        cmd_dx = 8'($urandom_range(0, 255));
        cmd_dy = 8'($urandom_range(0, 255));
        cmd_width = 8'($urandom_range(0, 255));
      end
      step();
      g++;
    end
    x_done = 1'b0;
    y_done = 1'b0;
    cmd_valid = 1'b0;
    n_cmp++;
    if (m_active) begin
      n_err++;
      $display("FAIL move_timeout actual=active required=idle");
    end
  endtask

  task automatic run_move(input int dx, input int dy, input int w, input int xdel, input int ydel,
                          input bit hold, input bit lit, input int lxw, input int lyw);
    start_move(dx, dy, w, hold);
    finish_move(xdel, ydel, hold, lit, (dx == 0) ? 0 : dx, (dy == 0) ? 0 : dy, lxw, lyw);
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_ready"}, cmd_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_xt"}, x_trigger, 1'b0);
    chk1({tag, "_yt"}, y_trigger, 1'b0);
    chk8({tag, "_xn"}, x_pulse_num, 8'd0);
    chk8({tag, "_yn"}, y_pulse_num, 8'd0);
    chk8({tag, "_xw"}, x_pulse_width, 8'd0);
    chk8({tag, "_yw"}, y_pulse_width, 8'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    step();
    chk1("rst_release_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    step();
    step();
    chk1("init_ready", cmd_ready, 1'b1);
    chk1("init_busy", busy, 1'b0);

    run_move(-4, 2, 2, 3, 3, 0, 1, 2, 4);
    run_move(0, 0, 5, 3, 3, 0, 1, 0, 0);
    chk1("zero_busy_after", busy, 1'b0);
    run_move(5, 0, 3, 4, 4, 0, 1, 3, 0);
    run_move(-128, 1, 200, 2, 5, 0, 1, 200, 255);
    run_move(3, 3, 7, 6, 2, 0, 1, 7, 7);
    run_move(10, -7, 9, 14, 4, 1, 1, 9, 12);
    run_move(6, 6, 1, 5, 5, 1, 1, 1, 1);

    // reset while dividing
    start_move(9, 4, 100, 0);
    repeat (5) step();
    pulse_reset();
    // reset while waiting for completions
    start_move(7, 2, 5, 0);
    for (int i = 0; i < 40 && tick_n < m_trig + 3; i++) step();
    pulse_reset();
    run_move(2, -6, 4, 3, 7, 0, 1, 12, 4);

    for (int n = 0; n < 24; n++) begin
      int rdx, rdy;
      rdx = ($urandom_range(0, 3) == 0) ? 0 : int'($signed(8'($urandom_range(0, 255))));
      rdy = ($urandom_range(0, 3) == 0) ? 0 : int'($signed(8'($urandom_range(0, 255))));
      run_move(rdx, rdy, $urandom_range(0, 255), $urandom_range(2, 12), $urandom_range(2, 12),
               1'($urandom_range(0, 1)), 0, 0, 0);
      repeat ($urandom_range(0, 2)) step();
    end
    chk1("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
